rib_dma: RTL and testbench

RIB_DMA -- requirements
Module: rib_dma

---
 rtl/rib_dma_pkg.sv | 23 ++
 rtl/rib_dma.sv | 171 +++++++++++++++++
 tb/tb_rib_dma.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rib_dma_pkg.sv
// Shared definitions for rib_dma: register offsets, CTRL/STATUS bit positions and FSM encoding.
package rib_dma_pkg;

  // Register index taken from addr_i[4:2]
  localparam logic [2:0] RegCtrl   = 3'd0;
  localparam logic [2:0] RegSrc    = 3'd1;
  localparam logic [2:0] RegDst    = 3'd2;
  localparam logic [2:0] RegLen    = 3'd3;
  localparam logic [2:0] RegStatus = 3'd4;

  localparam int unsigned CtrlStartBit  = 0;
  localparam int unsigned CtrlIntEnBit  = 1;
  localparam int unsigned StatusBusyBit = 0;
  localparam int unsigned StatusDoneBit = 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRd   = 2'd1,
    StWr   = 2'd2,
    StFin  = 2'd3
  } state_e;

endpackage

// File: rtl/rib_dma.sv
// Word-copy DMA engine with a RIB config slave and a RIB master port.
// Optional completion interrupt enabled by defining RIB_DMA_INT_EN.
module rib_dma
  import rib_dma_pkg::*;
#(
  parameter int unsigned LEN_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        m_req_o,
  output logic        m_we_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_data_o,
  input  logic [31:0] m_data_i,
  input  logic        m_ack_i,
  output logic        int_sig_o
);

  state_e           state_q, state_d;
  logic [31:0]      src_q, src_d, dst_q, dst_d;
  logic [31:0]      cur_src_q, cur_src_d, cur_dst_q, cur_dst_d, word_q, word_d;
  logic [LEN_W-1:0] len_q, len_d, rem_q, rem_d;
  logic             done_q, done_d;

  logic [2:0] reg_idx;
  logic       wr_en, ctrl_wr, src_wr, dst_wr, len_wr, status_wr;
  logic       start, busy, int_en;
  logic       unused_addr;

  assign reg_idx     = addr_i[4:2];
  assign unused_addr = ^{addr_i[31:5], addr_i[1:0]};
  assign wr_en       = req_i & we_i;
  assign ctrl_wr     = wr_en & (reg_idx == RegCtrl);
  assign src_wr      = wr_en & (reg_idx == RegSrc);
  assign dst_wr      = wr_en & (reg_idx == RegDst);
  assign len_wr      = wr_en & (reg_idx == RegLen);
  assign status_wr   = wr_en & (reg_idx == RegStatus);
  assign busy        = (state_q == StRd) | (state_q == StWr);
  assign start       = ctrl_wr & data_i[CtrlStartBit] & (state_q == StIdle);
  assign ack_o       = req_i;

`ifdef RIB_DMA_INT_EN
  logic int_en_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      int_en_q <= 1'b0;
    end else if (ctrl_wr) begin
      int_en_q <= data_i[CtrlIntEnBit];
    end
  end
  assign int_en    = int_en_q;
  assign int_sig_o = done_q & int_en_q;
`else
  assign int_en    = 1'b0;
  assign int_sig_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = (len_q == '0) ? StFin : StRd;
      StRd:   if (m_ack_i) state_d = StWr;
      StWr:   if (m_ack_i) state_d = (rem_q == LEN_W'(1)) ? StFin : StRd;
      StFin:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    m_req_o  = 1'b0;
    m_we_o   = 1'b0;
    m_addr_o = '0;
    m_data_o = '0;
    unique case (state_q)
      StRd: begin
        m_req_o  = 1'b1;
        m_addr_o = cur_src_q;
      end
      StWr: begin
        m_req_o  = 1'b1;
        m_we_o   = 1'b1;
        m_addr_o = cur_dst_q;
        m_data_o = word_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    cur_src_d = cur_src_q;
    cur_dst_d = cur_dst_q;
    rem_d     = rem_q;
    word_d    = word_q;
    done_d    = done_q;
    if (!busy) begin
      if (src_wr) src_d = {data_i[31:2], 2'b00};
      if (dst_wr) dst_d = {data_i[31:2], 2'b00};
      if (len_wr) len_d = data_i[LEN_W-1:0];
    end
    if (start) begin
      cur_src_d = src_q;
      cur_dst_d = dst_q;
      rem_d     = len_q;
      done_d    = 1'b0;
    end
    if (state_q == StRd && m_ack_i) word_d = m_data_i;
    if (state_q == StWr && m_ack_i) begin
      cur_src_d = cur_src_q + 32'd4;
      cur_dst_d = cur_dst_q + 32'd4;
      rem_d     = rem_q - LEN_W'(1);
    end
    if (status_wr && data_i[StatusDoneBit]) done_d = 1'b0;
    // Completion outranks a same-cycle software clear
    if (state_q == StFin) done_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      cur_src_q <= '0;
      cur_dst_q <= '0;
      rem_q     <= '0;
      word_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      cur_src_q <= cur_src_d;
      cur_dst_q <= cur_dst_d;
      rem_q     <= rem_d;
      word_q    <= word_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    data_o = '0;
    case (reg_idx)
      RegCtrl:   data_o[CtrlIntEnBit] = int_en;
      RegSrc:    data_o = src_q;
      RegDst:    data_o = dst_q;
      RegLen:    data_o = 32'(len_q);
      RegStatus: begin
        data_o[StatusBusyBit] = busy;
        data_o[StatusDoneBit] = done_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rib_dma.sv
// Randomized bench for rib_dma: bus-slave memory responder plus a word-copy reference model.
module tb_rib_dma;

  logic        clk, rst, req_i, we_i, ack_o;
  logic [31:0] addr_i, data_i, data_o;
  logic        m_req_o, m_we_o, m_ack_i, int_sig_o;
  logic [31:0] m_addr_o, m_data_o, m_data_i;

  rib_dma #(.LEN_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req_i),
    .we_i     (we_i),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .data_o   (data_o),
    .ack_o    (ack_o),
    .m_req_o  (m_req_o),
    .m_we_o   (m_we_o),
    .m_addr_o (m_addr_o),
    .m_data_o (m_data_o),
    .m_data_i (m_data_i),
    .m_ack_i  (m_ack_i),
    .int_sig_o(int_sig_o)
  );

`ifdef RIB_DMA_INT_EN
  localparam logic ExpInt = 1'b1;
`else
  localparam logic ExpInt = 1'b0;
`endif

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  txn_t        log_q[$];
  txn_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          req_cycles = 0;
  int          dmin = 0, dmax = 0;
  logic        int_en_sw = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // Master-side memory responder with randomized ack delay and hold-stability checks
  initial begin : responder
    int   wait_cnt, cur_delay;
    logic cap_we;
    logic [31:0] cap_addr, cap_data;
    wait_cnt = 0; cur_delay = 0;
    m_ack_i = 1'b0; m_data_i = '0;
    forever begin
      @(negedge clk);
      m_ack_i  = 1'b0;
      m_data_i = '0;
      if (rst || !m_req_o) begin
        wait_cnt = 0;
      end else begin
        req_cycles++;
        if (wait_cnt == 0) begin
          cap_we = m_we_o; cap_addr = m_addr_o; cap_data = m_data_o;
          cur_delay = $urandom_range(dmax, dmin);
          if (!m_we_o) check_eq("rd_mdata_zero", m_data_o, 32'h0);
        end else begin
          check_eq("hold_we", {31'b0, m_we_o}, {31'b0, cap_we});
          check_eq("hold_addr", m_addr_o, cap_addr);
          check_eq("hold_data", m_data_o, cap_data);
        end
        if (wait_cnt >= cur_delay) begin
          m_ack_i = 1'b1;
          if (m_we_o) begin
            mem[m_addr_o] = m_data_o;
            log_q.push_back('{we: 1'b1, addr: m_addr_o, data: m_data_o});
          end else begin
            m_data_i = mem_rd(m_addr_o);
            log_q.push_back('{we: 1'b0, addr: m_addr_o, data: m_data_i});
          end
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  task automatic cfg_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; addr_i = a; data_i = d;
    @(negedge clk);
    req_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic cfg_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; addr_i = a;
    #1;
    d = data_o;
    check_eq("ack_comb", {31'b0, ack_o}, 32'h1);
    req_i = 1'b0;
  endtask

  task automatic do_xfer(input logic [31:0] s, input logic [31:0] d, input int len,
                         input bit poke);
    logic [31:0] v, sa, da, w;
    bit done;
    sa = {s[31:2], 2'b00};
    da = {d[31:2], 2'b00};
    cfg_write(32'h04, s);
    cfg_write(32'h08, d);
    cfg_write(32'h0C, 32'(len));
    cfg_read(32'h04, v);
    check_eq("src_align", v, sa);
    cfg_read(32'h08, v);
    check_eq("dst_align", v, da);
    // Reference: sequential word copy over a snapshot of memory
    ref_mem = mem;
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      w = ref_rd(sa + 32'(4 * i));
      exp_q.push_back('{we: 1'b0, addr: sa + 32'(4 * i), data: w});
      ref_mem[da + 32'(4 * i)] = w;
      exp_q.push_back('{we: 1'b1, addr: da + 32'(4 * i), data: w});
    end
    log_q.delete();
    req_cycles = 0;
    cfg_write(32'h00, {30'b0, int_en_sw, 1'b1});
    if (len == 0) begin
      cfg_read(32'h10, v);
      check_eq("len0_done", v, 32'h2);
      repeat (3) @(negedge clk);
      check_eq("len0_noreq", 32'(req_cycles), 32'h0);
      return;
    end
    #1;
    check_eq("lat_req", {31'b0, m_req_o}, 32'h1);
    check_eq("lat_addr", m_addr_o, sa);
    if (poke) begin
      cfg_read(32'h10, v);
      check_eq("busy_status", v, 32'h1);
      cfg_write(32'h04, 32'h0000_DEAD);
      cfg_read(32'h04, v);
      check_eq("src_busy_wr", v, sa);
    end
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      cfg_read(32'h10, v);
      done = v[1];
    end
    check_eq("xfer_done", {31'b0, done}, 32'h1);
    check_eq("n_txn", 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      check_eq("txn_we", {31'b0, log_q[i].we}, {31'b0, exp_q[i].we});
      check_eq("txn_addr", log_q[i].addr, exp_q[i].addr);
      check_eq("txn_data", log_q[i].data, exp_q[i].data);
    end
    for (int i = 0; i < len; i++)
      check_eq("dst_mem", mem_rd(da + 32'(4 * i)), ref_rd(da + 32'(4 * i)));
    if (dmax == 0) check_eq("req_cycles", 32'(req_cycles), 32'(2 * len));
    cfg_read(32'h10, v);
    check_eq("status_fin", v, 32'h2);
  endtask

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] v;
    int snap;
    rst = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; data_i = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_mreq", {31'b0, m_req_o}, 32'h0);
    check_eq("rst_mwe", {31'b0, m_we_o}, 32'h0);
    check_eq("rst_maddr", m_addr_o, 32'h0);
    check_eq("rst_mdata", m_data_o, 32'h0);
    check_eq("rst_int", {31'b0, int_sig_o}, 32'h0);
    rst = 1'b0;
    for (int r = 0; r < 5; r++) begin
      cfg_read(32'(4 * r), v);
      check_eq("rst_reg", v, 32'h0);
    end
    cfg_write(32'h0C, 32'hFFFF_1234);
    cfg_read(32'h0C, v);
    check_eq("len_zext", v, 32'h0000_1234);
    cfg_write(32'h14, 32'hFFFF_FFFF);
    cfg_read(32'h14, v);
    check_eq("unmapped", v, 32'h0);

    dmin = 0; dmax = 0;
    do_xfer(32'h1000_0000, 32'h1000_0100, 4, 1'b0);
    do_xfer(32'h1000_0200, 32'h1000_0300, 0, 1'b0);
    dmin = 3; dmax = 3;
    do_xfer(32'h2000_0000, 32'h2000_0800, 3, 1'b0);
    do_xfer(32'h3000_0000, 32'h3000_1000, 4, 1'b1);
    dmin = 0; dmax = 0;
    do_xfer(32'hFFFF_FFFC, 32'h4000_0000, 2, 1'b0);
    if (log_q.size() >= 3) check_eq("wrap_addr", log_q[2].addr, 32'h0);
    else check_eq("wrap_txn_cnt", 32'(log_q.size()), 32'd4);

    int_en_sw = 1'b1;
    do_xfer(32'h5000_0000, 32'h5000_0100, 2, 1'b0);
    check_eq("int_sig", {31'b0, int_sig_o}, {31'b0, ExpInt});
    cfg_read(32'h00, v);
    check_eq("ctrl_inten", v, {30'b0, ExpInt, 1'b0});
    cfg_write(32'h10, 32'h2);
    #1;
    check_eq("int_clr", {31'b0, int_sig_o}, 32'h0);
    cfg_read(32'h10, v);
    check_eq("done_clr", v, 32'h0);

    for (int k = 0; k < 6; k++) begin
      int_en_sw = 1'($urandom_range(1, 0));
      dmin = 0; dmax = $urandom_range(2, 0);
      do_xfer($urandom, $urandom, $urandom_range(6, 1), 1'b0);
    end

    // Abort by reset in the middle of a transfer
    dmin = 1; dmax = 1;
    cfg_write(32'h04, 32'h6000_0000);
    cfg_write(32'h0C, 32'd8);
    cfg_write(32'h00, 32'h1);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("abort_mreq", {31'b0, m_req_o}, 32'h0);
    check_eq("abort_maddr", m_addr_o, 32'h0);
    snap = req_cycles;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("abort_noreq", 32'(req_cycles), 32'(snap));
    cfg_read(32'h10, v);
    check_eq("abort_status", v, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
